text_cursor_ctrl: RTL and testbench
===================================

Name: text_cursor_ctrl

Overview:
- Sequences the character buffer's single write port from the UART receive stream.
- Maintains a text cursor over the 80x30 tile grid and writes printable ASCII at that cursor.
- Interprets a small set of control codes (CR, LF, BS, FF).
- Clears lines and the full screen through timed write sequences.
- Sits between the uart receiver (o_wr/o_data) and buffer (wr_en/col_w/row_w/din); replaces the fixed col_w=0/row_w=0 tie-offs in top.

Parameters:
- NCOL, 80, number of text columns (640/8).
- NROW, 30, number of text rows (480/16).
- CLEAR_CHAR, 7'h20, code written when clearing a cell.

Ports:
- clk  in  1  system/pixel clock, 25 MHz.
- rstn  in  1  reset, synchronous, active-low.
- rx_valid  in  1  one-cycle strobe; a received byte is present (uart o_wr).
- rx_data  in  8  received byte (uart o_data).
- wr_en  out  1  buffer write strobe.
- col_w  out  7  buffer write column.
- row_w  out  5  buffer write row.
- din  out  7  buffer write data (ASCII code).
- cursor_col  out  7  current cursor column.
- cursor_row  out  5  current cursor row.
- busy  out  1  high while a clear sequence runs.
- overrun  out  1  sticky; a byte was dropped.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rstn; all outputs are registered.
- Reset values: wr_en=0, col_w=0, row_w=0, din=0, cursor_col=0, cursor_row=0, busy=0, overrun=0, state=IDLE, pending empty. Buffer contents are not touched by reset.
- States: IDLE, CLR_LINE, CLR_ALL. busy=1 exactly when state is not IDLE.
- Byte source in IDLE: the pending byte if valid, otherwise rx_data when rx_valid=1.
  - If both the pending byte and rx_valid are present, pending is consumed and the rx byte is latched into pending.
- Latency: a byte sampled at edge N produces its wr_en pulse and cursor update at edge N+1.
- Printable bytes (0x20..0x7E):
  - Outputs wr_en=1, col_w=cursor_col, row_w=cursor_row, din=byte[6:0].
  - If cursor_col<NCOL-1: cursor_col+1.
  - Otherwise newline: cursor_col=0, row advances, go to CLR_LINE.
- Row advance: cursor_row+1, wrapping NROW-1 -> 0. There is no scroll.
- CR (0x0D): cursor_col=0; no write.
- LF (0x0A): newline (col 0, row advance, CLR_LINE). The sequence CR LF gives the same result as LF alone.
- BS (0x08):
  - If cursor_col>0: cursor_col-1 and write CLEAR_CHAR at (cursor_col-1, cursor_row).
  - If cursor_col=0: no-op. BS never moves to the previous row.
- FF (0x0C): enter CLR_ALL.
- All other bytes (0x00..0x1F except the above, 0x7F, 0x80..0xFF): ignored; no write, no cursor change.
- CLR_LINE:
  - NCOL consecutive cycles with wr_en=1, din=CLEAR_CHAR, row_w=new cursor_row, col_w=0..NCOL-1.
  - Returns to IDLE the cycle after col NCOL-1 is written.
- CLR_ALL:
  - NCOL*NROW=2400 consecutive writes, row-major (row 0 col 0 .. row 29 col 79).
  - On exit, cursor=(0,0); return to IDLE.
- While busy, rx_valid=1:
  - If pending is empty, store the byte.
  - Otherwise drop the byte and set overrun=1. overrun clears only on reset.
  - Sizing: one pending entry suffices at 115200 baud (about 2170 cycles per byte, 2400-cycle worst clear).
- Pending is processed on the first IDLE cycle after a clear. If that byte is LF, FF or a wrapping printable, busy reasserts immediately.
- Reset asserted mid-clear: the sequence aborts at the next edge. Remaining cells keep their old contents; all outputs take reset values.
- wr_en is never high for more than one cell per cycle. col_w/row_w/din hold their last values when wr_en=0.
- Counter widths: col counter 7 bits, row counter 5 bits. No arithmetic exceeds NCOL-1/NROW-1 before wrap.

Decomposition:
- Shared package (text_pkg) holds:
  - NCOL/NROW constants, derived from Vwidth/Cwidth and Vheight/Cheight.
  - Control-code constants: ASCII_BS, ASCII_LF, ASCII_FF, ASCII_CR, ASCII_SPACE.
  - State enum for IDLE/CLR_LINE/CLR_ALL.
- One sub-module: clear_sequencer. Given start, mode (line/all) and start row, it emits the col/row write sweep and a done pulse.
- The main FSM, cursor and pending logic stay in text_cursor_ctrl.

Test Plan:
1. Reset, then bytes 'H'(0x48), 'i'(0x69) -> writes (0,0)=0x48 and (1,0)=0x69, each one cycle after its strobe; cursor=(2,0), busy=0.
2. Cursor at (79,3), send 'A' -> write (79,3)=0x41; cursor=(0,4); busy=1 for 80 cycles writing 0x20 to row 4 cols 0..79, then busy=0.
3. Cursor at (5,29), send LF -> cursor=(0,0), row 0 cleared over 80 cycles. Then send CR at col 5 -> col=0, no wr_en.
4. Cursor (0,2), send BS -> no write, cursor unchanged. Cursor (4,2), send BS -> write (3,2)=0x20, cursor=(3,2).
5. Send FF, then 'x' 100 cycles later and 'y' 2200 cycles later -> 2400 clear writes; 'x' pending, 'y' dropped with overrun=1; after clear, 'x' written at (0,0), cursor=(1,0).
6. Assert rstn=0 at clear write #500 -> next edge wr_en=0, busy=0, cursor=(0,0). Send 0x07 and 0xC1 -> ignored, no wr_en.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants and state type for the text cursor controller.
// The grid size comes from the 640x480 raster and the 8x16 glyph cell.
package text_pkg;

    localparam int VWIDTH  = 640;
    localparam int CWIDTH  = 8;
    localparam int VHEIGHT = 480;
    localparam int CHEIGHT = 16;

    localparam int NCOL = VWIDTH / CWIDTH;
    localparam int NROW = VHEIGHT / CHEIGHT;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_LINE = 2'd1,
        CLR_ALL  = 2'd2
    } state_t;

endpackage

// File: rtl/clear_sequencer.sv
// Walks the buffer column by column for a one-row or full-screen clear.
// done is high during the cycle that presents the final cell of the sweep.
module clear_sequencer
    import text_pkg::*;
#(
    parameter int NCOL = text_pkg::NCOL,
    parameter int NROW = text_pkg::NROW
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       mode_all,
    input  logic [4:0] start_row,
    output logic [6:0] col,
    output logic [4:0] row,
    output logic       done
);

    localparam logic [6:0] COL_LAST = 7'(NCOL - 1);
    localparam logic [4:0] ROW_LAST = 5'(NROW - 1);

    logic active;
    logic all_q;

    always_comb begin
        done = active && (col == COL_LAST) && (!all_q || (row == ROW_LAST));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active <= 1'b0;
            all_q  <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else if (start) begin
            active <= 1'b1;
            all_q  <= mode_all;
            col    <= '0;
            row    <= mode_all ? 5'd0 : start_row;
        end else if (active) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (done) begin
                    active <= 1'b0;
                end else begin
                    row <= (row == ROW_LAST) ? 5'd0 : row + 5'd1;
                end
            end else begin
                col <= col + 7'd1;
            end
        end
    end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Turns the UART byte stream into character-buffer writes with a text cursor,
// control-code handling and timed line/screen clears.
module text_cursor_ctrl
    import text_pkg::*;
#(
    parameter int         NCOL       = text_pkg::NCOL,
    parameter int         NROW       = text_pkg::NROW,
    parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [6:0] col_w,
    output logic [4:0] row_w,
    output logic [6:0] din,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy,
    output logic       overrun
);

    localparam logic [6:0] COL_LAST = 7'(NCOL - 1);
    localparam logic [4:0] ROW_LAST = 5'(NROW - 1);

    state_t     state;
    logic       pend_valid;
    logic [7:0] pend_data;

    logic       byte_valid;
    logic [7:0] src_byte;
    logic       is_print;
    logic       at_end;
    logic [4:0] next_row;
    logic       seq_start;
    logic       seq_all;
    logic [6:0] seq_col;
    logic [4:0] seq_row;
    logic       seq_done;

    always_comb begin
        byte_valid = (state == IDLE) && (pend_valid || rx_valid);
        src_byte   = pend_valid ? pend_data : rx_data;
        is_print   = (src_byte >= 8'h20) && (src_byte <= 8'h7E);
        at_end     = (cursor_col == COL_LAST);
        next_row   = (cursor_row == ROW_LAST) ? 5'd0 : cursor_row + 5'd1;
        seq_all    = byte_valid && (src_byte == ASCII_FF);
        seq_start  = seq_all ||
                     (byte_valid && ((is_print && at_end) || (src_byte == ASCII_LF)));
    end

    clear_sequencer #(
        .NCOL (NCOL),
        .NROW (NROW)
    ) u_clear (
        .clk       (clk),
        .rstn      (rstn),
        .start     (seq_start),
        .mode_all  (seq_all),
        .start_row (next_row),
        .col       (seq_col),
        .row       (seq_row),
        .done      (seq_done)
    );

    // One-deep holding slot: filled while a clear runs, drained first in IDLE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            overrun    <= 1'b0;
        end else if (state == IDLE) begin
            if (pend_valid) begin
                pend_valid <= rx_valid;
                if (rx_valid) pend_data <= rx_data;
            end
        end else if (rx_valid) begin
            if (!pend_valid) begin
                pend_valid <= 1'b1;
                pend_data  <= rx_data;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            col_w      <= '0;
            row_w      <= '0;
            din        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        if (is_print) begin
                            wr_en <= 1'b1;
                            col_w <= cursor_col;
                            row_w <= cursor_row;
                            din   <= src_byte[6:0];
                            if (at_end) begin
                                cursor_col <= '0;
                                cursor_row <= next_row;
                                state      <= CLR_LINE;
                                busy       <= 1'b1;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                            end
                        end else begin
                            case (src_byte)
                                ASCII_CR: cursor_col <= '0;
                                ASCII_LF: begin
                                    cursor_col <= '0;
                                    cursor_row <= next_row;
                                    state      <= CLR_LINE;
                                    busy       <= 1'b1;
                                end
                                ASCII_BS: begin
                                    if (cursor_col != 7'd0) begin
                                        cursor_col <= cursor_col - 7'd1;
                                        wr_en      <= 1'b1;
                                        col_w      <= cursor_col - 7'd1;
                                        row_w      <= cursor_row;
                                        din        <= CLEAR_CHAR;
                                    end
                                end
                                ASCII_FF: begin
                                    state <= CLR_ALL;
                                    busy  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_LINE, CLR_ALL: begin
                    wr_en <= 1'b1;
                    col_w <= seq_col;
                    row_w <= seq_row;
                    din   <= CLEAR_CHAR;
                    if (seq_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (state == CLR_ALL) begin
                            cursor_col <= '0;
                            cursor_row <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: printing, control codes, clears,
// pending/overrun handling and reset during a clear.
module tb_text_cursor_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [6:0] col_w;
    logic [4:0] row_w;
    logic [6:0] din;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #20 clk = ~clk;

    text_cursor_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wr_en      (wr_en),
        .col_w      (col_w),
        .row_w      (row_w),
        .din        (din),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drives a one-cycle strobe; returns at the negedge one cycle after it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic chk_write(input string tag, input int c, input int r, input int d);
        chk({tag, ".wr_en"}, wr_en, 1);
        chk({tag, ".col_w"}, col_w, c);
        chk({tag, ".row_w"}, row_w, r);
        chk({tag, ".din"},   din,   d);
    endtask

    task automatic chk_cursor(input string tag, input int c, input int r);
        chk({tag, ".cursor_col"}, cursor_col, c);
        chk({tag, ".cursor_row"}, cursor_row, r);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk({tag, ".idle_timeout"}, busy, 0);
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b);
    endtask

    task automatic chk_line_clear(input string tag, input int r);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            chk_write(tag, c, r, 8'h20);
            chk({tag, ".busy"}, busy, (c == 79) ? 0 : 1);
        end
        @(negedge clk);
        chk({tag, ".wr_en_after"}, wr_en, 0);
    endtask

    initial begin
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst.wr_en", wr_en, 0);
        chk("rst.col_w", col_w, 0);
        chk("rst.row_w", row_w, 0);
        chk("rst.din", din, 0);
        chk_cursor("rst", 0, 0);
        chk("rst.busy", busy, 0);
        chk("rst.overrun", overrun, 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: two printables back to back
        send_byte(8'h48);
        chk_write("t1_H", 0, 0, 8'h48);
        chk_cursor("t1_H", 1, 0);
        send_byte(8'h69);
        chk_write("t1_i", 1, 0, 8'h69);
        chk_cursor("t1_i", 2, 0);
        chk("t1.busy", busy, 0);

        // 2: printable in the last column wraps and clears the new row
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h0A);
            wait_idle("t2_lf");
        end
        chk_cursor("t2_pre_lf", 0, 3);
        send_n(8'h61, 79);
        chk_cursor("t2_pre", 79, 3);
        send_byte(8'h41);
        chk_write("t2_A", 79, 3, 8'h41);
        chk_cursor("t2_A", 0, 4);
        chk("t2.busy", busy, 1);
        chk_line_clear("t2_clr", 4);

        // 3: LF on the last row wraps to row 0, then CR
        for (int i = 0; i < 25; i++) begin
            send_byte(8'h0A);
            wait_idle("t3_lf");
        end
        send_n(8'h62, 5);
        chk_cursor("t3_pre", 5, 29);
        send_byte(8'h0A);
        chk("t3_lf.wr_en", wr_en, 0);
        chk_cursor("t3_lf", 0, 0);
        chk("t3_lf.busy", busy, 1);
        chk_line_clear("t3_clr", 0);
        send_n(8'h63, 5);
        chk_cursor("t3_precr", 5, 0);
        send_byte(8'h0D);
        chk("t3_cr.wr_en", wr_en, 0);
        chk_cursor("t3_cr", 0, 0);
        chk("t3_cr.busy", busy, 0);

        // 4: BS at column 0 and mid-row
        send_byte(8'h0A);
        wait_idle("t4_lf1");
        send_byte(8'h0A);
        wait_idle("t4_lf2");
        send_byte(8'h08);
        chk("t4_bs0.wr_en", wr_en, 0);
        chk_cursor("t4_bs0", 0, 2);
        send_n(8'h64, 4);
        send_byte(8'h08);
        chk_write("t4_bs", 3, 2, 8'h20);
        chk_cursor("t4_bs", 3, 2);

        // 5: full clear with one pending byte and one dropped byte
        send_byte(8'h0C);
        chk("t5_ff.wr_en", wr_en, 0);
        chk("t5_ff.busy", busy, 1);
        for (int i = 0; i < 2400; i++) begin
            rx_valid = (i == 100) || (i == 2200);
            rx_data  = (i == 2200) ? 8'h79 : 8'h78;
            @(negedge clk);
            chk_write("t5_clr", i % 80, i / 80, 8'h20);
            chk("t5_clr.busy", busy, (i == 2399) ? 0 : 1);
        end
        rx_valid = 1'b0;
        chk("t5.overrun", overrun, 1);
        chk_cursor("t5_end", 0, 0);
        @(negedge clk);
        chk_write("t5_x", 0, 0, 8'h78);
        chk_cursor("t5_x", 1, 0);
        chk("t5_x.busy", busy, 0);
        @(negedge clk);
        chk("t5_y.wr_en", wr_en, 0);
        chk_cursor("t5_y", 1, 0);

        // 6: reset in the middle of a full clear
        send_byte(8'h0C);
        repeat (500) @(negedge clk);
        chk_write("t6_w500", 19, 6, 8'h20);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst.wr_en", wr_en, 0);
        chk("t6_rst.busy", busy, 0);
        chk("t6_rst.overrun", overrun, 0);
        chk_cursor("t6_rst", 0, 0);
        rstn = 1'b1;
        @(negedge clk);
        send_byte(8'h07);
        chk("t6_bel.wr_en", wr_en, 0);
        chk_cursor("t6_bel", 0, 0);
        send_byte(8'hC1);
        chk("t6_hi.wr_en", wr_en, 0);
        chk_cursor("t6_hi", 0, 0);
        chk("t6_hi.busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
